fence_flush_sequencer: RTL and testbench



---
 rtl/fence_flush_sequencer_pkg.sv | 18 +
 rtl/fence_flush_sequencer_if.sv | 12 +
 rtl/fence_flush_sequencer_lzc.sv | 22 ++
 rtl/fence_flush_sequencer.sv | 154 +++++++++++++++
 tb/tb_fence_flush_sequencer.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fence_flush_sequencer_pkg.sv
// rtl/fence_flush_sequencer_pkg.sv - shared target indices, default masks and flush cause encoding
package fence_flush_sequencer_pkg;

    localparam int unsigned FLUSH_TGT_DCACHE = 0;
    localparam int unsigned FLUSH_TGT_ICACHE = 1;

    localparam logic [1:0] DEFAULT_FENCE_MASK   = 2'b01 << FLUSH_TGT_DCACHE;
    localparam logic [1:0] DEFAULT_FENCE_I_MASK = (2'b01 << FLUSH_TGT_DCACHE) | (2'b01 << FLUSH_TGT_ICACHE);

    // Highest-priority pipeline event seen in a cycle; decides the flush pulse pattern.
    typedef enum logic [1:0] {
        CAUSE_NONE,
        CAUSE_MISPREDICT,
        CAUSE_FENCE,
        CAUSE_EXCEPTION
    } flush_cause_e;

endpackage

// File: rtl/fence_flush_sequencer_if.sv
// rtl/fence_flush_sequencer_if.sv - per-target cache flush req/ack handshake
interface fence_flush_sequencer_if #(
    parameter int unsigned NR_TARGETS = 2
);

    logic [NR_TARGETS-1:0] flush_req;
    logic [NR_TARGETS-1:0] flush_ack;

    modport master (output flush_req, input flush_ack);
    modport slave  (input flush_req, output flush_ack);

endinterface

// File: rtl/fence_flush_sequencer_lzc.sv
// rtl/fence_flush_sequencer_lzc.sv - trailing-zero count: index of the lowest set bit
module fence_flush_sequencer_lzc #(
    parameter int unsigned WIDTH = 2,
    localparam int unsigned CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [CW-1:0]    cnt_o,
    output logic             empty_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in_i[i]) begin
                cnt_o = CW'(i);
            end
        end
    end

    assign empty_o = ~|in_i;

endmodule

// File: rtl/fence_flush_sequencer.sv
// rtl/fence_flush_sequencer.sv - pipeline flush pulses plus fence-driven cache maintenance sequencing
module fence_flush_sequencer
    import fence_flush_sequencer_pkg::*;
#(
    parameter int unsigned           NR_TARGETS     = 2,
    parameter logic [NR_TARGETS-1:0] FENCE_MASK     = NR_TARGETS'(DEFAULT_FENCE_MASK),
    parameter logic [NR_TARGETS-1:0] FENCE_I_MASK   = NR_TARGETS'(DEFAULT_FENCE_I_MASK),
    parameter bit                    SEQUENTIAL     = 1'b0,
    parameter int unsigned           TIMEOUT_CYCLES = 0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           fence_i,
    input  logic                           fence_i_i,
    input  logic                           sfence_vma_i,
    input  logic                           flush_csr_i,
    input  logic                           mispredict_i,
    input  logic                           ex_valid_i,
    input  logic                           eret_i,
    input  logic                           set_debug_pc_i,
    output logic                           set_pc_commit_o,
    output logic                           flush_if_o,
    output logic                           flush_unissued_instr_o,
    output logic                           flush_id_o,
    output logic                           flush_ex_o,
    output logic                           flush_bp_o,
    output logic                           flush_tlb_o,
    fence_flush_sequencer_if.master        cache,
    output logic                           halt_o,
    output logic                           busy_o,
    output logic                           flush_timeout_o
);

    logic [NR_TARGETS-1:0] pending_q, pending_d;
    logic [NR_TARGETS-1:0] req;
    logic [NR_TARGETS-1:0] acc;
    logic [NR_TARGETS-1:0] masks;
    logic                  busy;
    logic                  wd_fire;
    flush_cause_e          cause;

    assign busy = |pending_q;

    generate
        if (SEQUENTIAL) begin : g_seq
            localparam int unsigned IW = (NR_TARGETS > 1) ? $clog2(NR_TARGETS) : 1;
            logic [IW-1:0] low_idx;
            logic          none;

            fence_flush_sequencer_lzc #(
                .WIDTH (NR_TARGETS)
            ) u_lzc (
                .in_i    (pending_q),
                .cnt_o   (low_idx),
                .empty_o (none)
            );

            assign req = none ? '0 : (NR_TARGETS'(1) << low_idx);
        end else begin : g_par
            assign req = pending_q;
        end
    endgenerate

    always_comb begin
        set_pc_commit_o        = 1'b0;
        flush_if_o             = 1'b0;
        flush_unissued_instr_o = 1'b0;
        flush_id_o             = 1'b0;
        flush_ex_o             = 1'b0;
        flush_bp_o             = 1'b0;
        flush_tlb_o            = 1'b0;

        if (ex_valid_i || eret_i || set_debug_pc_i) begin
            cause = CAUSE_EXCEPTION;
        end else if (fence_i || fence_i_i || sfence_vma_i || flush_csr_i) begin
            cause = CAUSE_FENCE;
        end else if (mispredict_i) begin
            cause = CAUSE_MISPREDICT;
        end else begin
            cause = CAUSE_NONE;
        end

        case (cause)
            CAUSE_EXCEPTION: begin
                flush_if_o             = 1'b1;
                flush_unissued_instr_o = 1'b1;
                flush_id_o             = 1'b1;
                flush_ex_o             = 1'b1;
                flush_bp_o             = 1'b1;
            end
            CAUSE_FENCE: begin
                set_pc_commit_o        = 1'b1;
                flush_if_o             = 1'b1;
                flush_unissued_instr_o = 1'b1;
                flush_id_o             = 1'b1;
                flush_ex_o             = 1'b1;
                flush_tlb_o            = sfence_vma_i;
            end
            CAUSE_MISPREDICT: begin
                flush_if_o             = 1'b1;
                flush_unissued_instr_o = 1'b1;
            end
            default: begin
            end
        endcase

        // Fence masks survive a same-cycle exception; a set in the ack cycle wins over the clear.
        acc   = req & cache.flush_ack;
        masks = (fence_i ? FENCE_MASK : '0) | (fence_i_i ? FENCE_I_MASK : '0);
        if (wd_fire) begin
            pending_d = masks;
        end else begin
            pending_d = (pending_q & ~acc) | masks;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wd
            localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
            logic [CW-1:0] cnt_q;
            logic          new_fence;

            assign new_fence = fence_i | fence_i_i;
            assign wd_fire   = (cnt_q == CW'(TIMEOUT_CYCLES));

            // Progress (ack or fresh fence) restarts the window; saturates rather than wrapping.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_q <= '0;
                end else if (wd_fire || (|acc) || new_fence || !busy) begin
                    cnt_q <= '0;
                end else if (cnt_q != CW'(TIMEOUT_CYCLES)) begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end else begin : g_no_wd
            assign wd_fire = 1'b0;
        end
    endgenerate

    assign cache.flush_req = req;
    assign busy_o          = busy;
    assign halt_o          = busy;
    assign flush_timeout_o = wd_fire;

endmodule

// File: tb/tb_fence_flush_sequencer.sv
// tb/tb_fence_flush_sequencer.sv - randomized and directed checks of four configurations against a queue-free reference model
module tb_fence_flush_sequencer;

    localparam int NI = 4;
    localparam int F_REQ = 0, F_HALT = 1, F_BUSY = 2, F_TMO = 3, F_SETPC = 4,
                   F_BP = 5, F_IF = 6, F_TLB = 7, F_ID = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic s_fence = 1'b0, s_fence_i = 1'b0, s_sfence = 1'b0, s_csr = 1'b0;
    logic s_mis = 1'b0, s_ex = 1'b0, s_eret = 1'b0, s_dbg = 1'b0;
    logic [7:0] ack [NI];

    logic [7:0] d_req [NI];
    logic d_halt [NI], d_busy [NI], d_tmo [NI], d_setpc [NI], d_if [NI], d_un [NI];
    logic d_id [NI], d_ex [NI], d_bp [NI], d_tlb [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned NR = (g == 3) ? 4 : 2;
        localparam logic [NR-1:0] FM  = (g == 3) ? NR'(3) : NR'(1);
        localparam logic [NR-1:0] FIM = (g == 3) ? NR'(15) : NR'(3);
        localparam int unsigned TMO = (g == 2) ? 4 : ((g == 3) ? 6 : 0);

        fence_flush_sequencer_if #(.NR_TARGETS(NR)) bus ();
        assign bus.flush_ack = ack[g][NR-1:0];
        assign d_req[g] = 8'(bus.flush_req);

        fence_flush_sequencer #(
            .NR_TARGETS     (NR),
            .FENCE_MASK     (FM),
            .FENCE_I_MASK   (FIM),
            .SEQUENTIAL     (g == 1 || g == 3),
            .TIMEOUT_CYCLES (TMO)
        ) u_dut (
            .clk_i                  (clk),
            .rst_i                  (rst),
            .fence_i                (s_fence),
            .fence_i_i              (s_fence_i),
            .sfence_vma_i           (s_sfence),
            .flush_csr_i            (s_csr),
            .mispredict_i           (s_mis),
            .ex_valid_i             (s_ex),
            .eret_i                 (s_eret),
            .set_debug_pc_i         (s_dbg),
            .set_pc_commit_o        (d_setpc[g]),
            .flush_if_o             (d_if[g]),
            .flush_unissued_instr_o (d_un[g]),
            .flush_id_o             (d_id[g]),
            .flush_ex_o             (d_ex[g]),
            .flush_bp_o             (d_bp[g]),
            .flush_tlb_o            (d_tlb[g]),
            .cache                  (bus),
            .halt_o                 (d_halt[g]),
            .busy_o                 (d_busy[g]),
            .flush_timeout_o        (d_tmo[g])
        );
    end

    function automatic bit seq_of(int i); return (i == 1 || i == 3); endfunction
    function automatic int tmo_of(int i); return (i == 2) ? 4 : ((i == 3) ? 6 : 0); endfunction
    function automatic logic [7:0] fm_of(int i); return (i == 3) ? 8'h03 : 8'h01; endfunction
    function automatic logic [7:0] fim_of(int i); return (i == 3) ? 8'h0f : 8'h03; endfunction

    function automatic logic [7:0] lowbit(logic [7:0] v);
        for (int b = 0; b < 8; b++) begin
            if (v[b]) return 8'(1) << b;
        end
        return 8'h00;
    endfunction

    // Reference state: which targets still owe an ack, and idle-progress cycles seen.
    logic [7:0] m_pend [NI];
    int         m_cnt [NI];
    int         cyc = 0;

    always @(posedge clk) begin
        logic [7:0] r, a, mk;
        cyc = cyc + 1;
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                m_pend[i] = 8'h00;
                m_cnt[i]  = 0;
            end else begin
                r  = seq_of(i) ? lowbit(m_pend[i]) : m_pend[i];
                a  = ack[i] & r;
                mk = (s_fence ? fm_of(i) : 8'h00) | (s_fence_i ? fim_of(i) : 8'h00);
                if (tmo_of(i) > 0 && m_cnt[i] == tmo_of(i)) begin
                    m_pend[i] = mk;
                    m_cnt[i]  = 0;
                end else begin
                    if (a != 0 || s_fence || s_fence_i || m_pend[i] == 0) m_cnt[i] = 0;
                    else if (m_cnt[i] < tmo_of(i)) m_cnt[i] = m_cnt[i] + 1;
                    m_pend[i] = (m_pend[i] & ~a) | mk;
                end
            end
        end
    end

    typedef struct { int cyc; int inst; int fld; logic [7:0] val; } lit_t;
    lit_t lit_q[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cycle %0d: actual=%h expected=%h", nm, i, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] dut_fld(int i, int f);
        case (f)
            F_REQ:   return d_req[i];
            F_HALT:  return 8'(d_halt[i]);
            F_BUSY:  return 8'(d_busy[i]);
            F_TMO:   return 8'(d_tmo[i]);
            F_SETPC: return 8'(d_setpc[i]);
            F_BP:    return 8'(d_bp[i]);
            F_IF:    return 8'(d_if[i]);
            F_TLB:   return 8'(d_tlb[i]);
            default: return 8'(d_id[i]);
        endcase
    endfunction

    function automatic string fld_name(int f);
        case (f)
            F_REQ: return "lit_req"; F_HALT: return "lit_halt"; F_BUSY: return "lit_busy";
            F_TMO: return "lit_timeout"; F_SETPC: return "lit_set_pc"; F_BP: return "lit_flush_bp";
            F_IF: return "lit_flush_if"; F_TLB: return "lit_flush_tlb"; default: return "lit_flush_id";
        endcase
    endfunction

    always @(negedge clk) begin
        logic exc, cf;
        logic [7:0] e_req;
        if (cyc >= 1) begin
            exc = s_ex | s_eret | s_dbg;
            cf  = s_fence | s_fence_i | s_sfence | s_csr;
            for (int i = 0; i < NI; i++) begin
                e_req = seq_of(i) ? lowbit(m_pend[i]) : m_pend[i];
                check("req", i, d_req[i], e_req);
                check("busy", i, 8'(d_busy[i]), 8'(m_pend[i] != 0));
                check("halt", i, 8'(d_halt[i]), 8'(m_pend[i] != 0));
                check("timeout", i, 8'(d_tmo[i]), 8'(tmo_of(i) > 0 && m_cnt[i] == tmo_of(i)));
                check("set_pc", i, 8'(d_setpc[i]), 8'(cf && !exc));
                check("flush_if", i, 8'(d_if[i]), 8'(exc || cf || s_mis));
                check("flush_unissued", i, 8'(d_un[i]), 8'(exc || cf || s_mis));
                check("flush_id", i, 8'(d_id[i]), 8'(exc || cf));
                check("flush_ex", i, 8'(d_ex[i]), 8'(exc || cf));
                check("flush_bp", i, 8'(d_bp[i]), 8'(exc));
                check("flush_tlb", i, 8'(d_tlb[i]), 8'(s_sfence && !exc));
            end
            for (int k = 0; k < lit_q.size(); k++) begin
                if (lit_q[k].cyc == cyc)
                    check(fld_name(lit_q[k].fld), lit_q[k].inst,
                          dut_fld(lit_q[k].inst, lit_q[k].fld), lit_q[k].val);
            end
        end
    end

    task automatic lit(input int c, input int i, input int f, input logic [7:0] v);
        lit_t e;
        e.cyc = c; e.inst = i; e.fld = f; e.val = v;
        lit_q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_acks();
        for (int i = 0; i < NI; i++) ack[i] = 8'h00;
    endtask

    initial begin
        clear_acks();
        // Parallel / ordered fence.i, and the watchdog abort on the TIMEOUT=4 instance.
        lit(5, 0, F_SETPC, 1); lit(5, 0, F_IF, 1); lit(5, 0, F_BP, 0); lit(5, 0, F_REQ, 0);
        lit(6, 0, F_REQ, 3); lit(6, 0, F_HALT, 1); lit(9, 0, F_REQ, 1);
        lit(12, 0, F_HALT, 1); lit(13, 0, F_HALT, 0);
        lit(6, 1, F_REQ, 1); lit(10, 1, F_REQ, 2); lit(11, 1, F_REQ, 2); lit(12, 1, F_BUSY, 0);
        lit(9, 2, F_TMO, 0); lit(10, 2, F_TMO, 1); lit(10, 2, F_REQ, 3);
        lit(11, 2, F_REQ, 0); lit(11, 2, F_TMO, 0); lit(6, 3, F_REQ, 1);
        // Merge while busy, spurious ack, set-wins.
        lit(21, 0, F_REQ, 1); lit(22, 0, F_REQ, 1); lit(23, 0, F_REQ, 3); lit(25, 0, F_REQ, 2);
        lit(27, 0, F_BUSY, 0); lit(23, 1, F_REQ, 1); lit(25, 1, F_REQ, 2);
        lit(32, 0, F_BUSY, 0); lit(35, 0, F_REQ, 1); lit(36, 0, F_BUSY, 0);
        // Exception with fence, sfence.vma, mispredict.
        lit(40, 0, F_SETPC, 0); lit(40, 0, F_BP, 1); lit(40, 0, F_IF, 1); lit(41, 0, F_REQ, 1);
        lit(44, 0, F_TLB, 1); lit(44, 0, F_SETPC, 1); lit(45, 0, F_IF, 1); lit(45, 0, F_ID, 0);
        lit(45, 0, F_SETPC, 0);
        // Reset mid-sequence and a late ack.
        lit(51, 0, F_REQ, 3); lit(52, 0, F_HALT, 1); lit(53, 0, F_REQ, 0); lit(53, 0, F_HALT, 0);
        lit(54, 0, F_REQ, 0); lit(53, 1, F_BUSY, 0);

        wait_cyc(3);  rst = 1'b0;
        wait_cyc(5);  s_fence_i = 1'b1;
        wait_cyc(6);  s_fence_i = 1'b0;
        wait_cyc(8);  ack[0] = 8'h02;
        wait_cyc(9);  ack[0] = 8'h00; ack[1] = 8'h01;
        wait_cyc(10); ack[1] = 8'h00;
        wait_cyc(11); ack[1] = 8'h02;
        wait_cyc(12); ack[1] = 8'h00; ack[0] = 8'h01;
        wait_cyc(13); ack[0] = 8'h00;

        wait_cyc(20); s_fence = 1'b1;
        wait_cyc(21); s_fence = 1'b0; ack[0] = 8'h02; ack[2] = 8'h02;
        wait_cyc(22); clear_acks(); s_fence_i = 1'b1;
        wait_cyc(23); s_fence_i = 1'b0;
        wait_cyc(24); ack[0] = 8'h01; ack[1] = 8'h01; ack[2] = 8'h01;
        wait_cyc(25); clear_acks();
        wait_cyc(26); ack[0] = 8'h02; ack[1] = 8'h02; ack[2] = 8'h02;
        wait_cyc(27); clear_acks();

        wait_cyc(30); s_fence = 1'b1;
        wait_cyc(31); s_fence = 1'b0; ack[0] = 8'h01;
        wait_cyc(32); ack[0] = 8'h00;
        wait_cyc(33); s_fence = 1'b1;
        wait_cyc(34); ack[0] = 8'h01;
        wait_cyc(35); s_fence = 1'b0;
        wait_cyc(36); ack[0] = 8'h00;

        wait_cyc(40); s_ex = 1'b1; s_fence = 1'b1;
        wait_cyc(41); s_ex = 1'b0; s_fence = 1'b0;
        wait_cyc(42); ack[0] = 8'h01;
        wait_cyc(43); ack[0] = 8'h00;
        wait_cyc(44); s_sfence = 1'b1;
        wait_cyc(45); s_sfence = 1'b0; s_mis = 1'b1;
        wait_cyc(46); s_mis = 1'b0;

        wait_cyc(50); s_fence_i = 1'b1;
        wait_cyc(51); s_fence_i = 1'b0;
        wait_cyc(52); rst = 1'b1;
        wait_cyc(53); rst = 1'b0; ack[0] = 8'h03; ack[1] = 8'h03;
        wait_cyc(54); clear_acks();

        for (int c = 60; c < 4000; c++) begin
            wait_cyc(c);
            rst       = ($urandom_range(0, 299) == 0);
            s_fence   = ($urandom_range(0, 9) == 0);
            s_fence_i = ($urandom_range(0, 11) == 0);
            s_sfence  = ($urandom_range(0, 14) == 0);
            s_csr     = ($urandom_range(0, 14) == 0);
            s_mis     = ($urandom_range(0, 9) == 0);
            s_ex      = ($urandom_range(0, 39) == 0);
            s_eret    = ($urandom_range(0, 39) == 0);
            s_dbg     = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < NI; i++) ack[i] = 8'($urandom & $urandom);
        end

        wait_cyc(4000);
        rst = 1'b0; s_fence = 1'b0; s_fence_i = 1'b0; s_sfence = 1'b0; s_csr = 1'b0;
        s_mis = 1'b0; s_ex = 1'b0; s_eret = 1'b0; s_dbg = 1'b0;
        clear_acks();
        wait_cyc(4005);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
